// File: rtl/gray_counter_if.sv
// gray_counter_if: control and output bundle of the Gray-code counter.
// The counter has no valid/ready handshake: en, load, load_gray (and up_dn
// when GRAY_COUNTER_UPDN_EN is defined) are sampled on every rising clk edge.
// gray_out, binary_out and wrap are driven straight from flops and are valid
// on every cycle after reset.
// Modports:
// - master: the user of the counter.
// - slave:  the counter itself.
interface gray_counter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_gray;
`ifdef GRAY_COUNTER_UPDN_EN
  logic                  up_dn;
`endif
  logic [DATA_WIDTH-1:0] gray_out;
  logic [DATA_WIDTH-1:0] binary_out;
  logic                  wrap;

  modport master (
    output en,
    output load,
    output load_gray,
`ifdef GRAY_COUNTER_UPDN_EN
    output up_dn,
`endif
    input  gray_out,
    input  binary_out,
    input  wrap
  );

  modport slave (
    input  en,
    input  load,
    input  load_gray,
`ifdef GRAY_COUNTER_UPDN_EN
    input  up_dn,
`endif
    output gray_out,
    output binary_out,
    output wrap
  );
endinterface

// File: rtl/gray_counter.sv
// gray_counter: registered Gray-code counter with parallel Gray-coded load.
//
// The counter keeps a binary count and registers its Gray encoding alongside
// it. Both registers are computed from the same next value, so gray_out and
// binary_out always describe the same count.
//
// Build option:
// - GRAY_COUNTER_UPDN_EN: adds the up_dn input (1 = up, 0 = down) and the
//   decrement path. Without it the counter is up-only.
//
// Priority on each edge is rst > load > en > hold. A load never raises wrap.
module gray_counter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  gray_counter_if.slave    bus
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;

  logic [DATA_WIDTH-1:0] step_bin;
  logic                  step_wraps;
  logic [DATA_WIDTH-1:0] load_bin;

  // Next count for an en step and whether that step crosses the wrap boundary.
  always_comb begin
    step_bin   = bin_q + ONE;
    step_wraps = &bin_q;
`ifdef GRAY_COUNTER_UPDN_EN
    if (!bus.up_dn) begin
      step_bin   = bin_q - ONE;
      step_wraps = ~|bin_q;
    end
`endif
  end

  // Gray-to-binary decode of the load value: bit i is the XOR of all
  // load_gray bits from the MSB down to bit i.
  always_comb begin
    load_bin                 = '0;
    load_bin[DATA_WIDTH-1]   = bus.load_gray[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ bus.load_gray[i];
    end
  end

  // Next-state selection: load beats en, and hold keeps the count.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      bin_d  = load_bin;
      gray_d = bus.load_gray;
    end else if (bus.en) begin
      bin_d  = step_bin;
      gray_d = step_bin ^ (step_bin >> 1);
      wrap_d = step_wraps;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.gray_out   = gray_q;
  assign bus.binary_out = bin_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed test of gray_counter at DATA_WIDTH=4.
module tb_gray_counter;

  localparam int W = 4;

  logic clk;
  logic rst;

  gray_counter_if #(.DATA_WIDTH(W)) bus ();

  gray_counter #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected Gray sequence after each en edge, starting from 0.
  logic [W-1:0] gray_tbl [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [W-1:0] bin_tbl  [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                  4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; inputs settle after it and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] g, input logic [W-1:0] b,
                           input logic w);
    check_eq({tag, "_gray"}, 32'(bus.gray_out), 32'(g));
    check_eq({tag, "_bin"},  32'(bus.binary_out), 32'(b));
    check_eq({tag, "_wrap"}, 32'(bus.wrap), 32'(w));
  endtask

  logic [W-1:0] prev_gray;

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.load      = 1'b1;
    bus.load_gray = 4'hF;
`ifdef GRAY_COUNTER_UPDN_EN
    bus.up_dn     = 1'b1;
`endif

    // Reset wins over load and en.
    step();
    check_out("reset", 4'h0, 4'h0, 1'b0);

    // Full up cycle with single-bit Gray changes and wrap only after F->0.
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.en   = 1'b1;
    prev_gray = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_out($sformatf("up%0d", i), gray_tbl[i], bin_tbl[i], (i == 15));
      check_eq($sformatf("hamming%0d", i), 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
      prev_gray = bus.gray_out;
    end

    // Load with en: load wins, then one further count.
    bus.load      = 1'b1;
    bus.load_gray = 4'hC;
    bus.en        = 1'b1;
    step();
    check_out("load_c", 4'hC, 4'h8, 1'b0);
    bus.load = 1'b0;
    step();
    check_out("load_c_inc", 4'hD, 4'h9, 1'b0);

    // Load of gray 8 (binary F) never wraps; the next en step does.
    bus.load      = 1'b1;
    bus.load_gray = 4'h8;
    step();
    check_out("load_f", 4'h8, 4'hF, 1'b0);
    bus.load = 1'b0;
    step();
    check_out("wrap_after_load", 4'h0, 4'h0, 1'b1);
    bus.en = 1'b0;
    step();
    check_out("wrap_not_sticky", 4'h0, 4'h0, 1'b0);

    // Hold at binary 5 (gray 7) for 10 cycles.
    bus.load      = 1'b1;
    bus.load_gray = 4'h7;
    step();
    check_out("load_5", 4'h7, 4'h5, 1'b0);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 4'h7, 4'h5, 1'b0);
    end

    // Mid-count reset at binary B (gray E), then count resumes from 1.
    bus.load      = 1'b1;
    bus.load_gray = 4'hE;
    step();
    check_out("load_b", 4'hE, 4'hB, 1'b0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    rst      = 1'b1;
    step();
    check_out("mid_rst", 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    step();
    check_out("resume1", 4'h1, 4'h1, 1'b0);
    step();
    check_out("resume2", 4'h3, 4'h2, 1'b0);

`ifdef GRAY_COUNTER_UPDN_EN
    // Down wrap from reset, then a further down step and a direction change.
    rst = 1'b1;
    step();
    check_out("dn_reset", 4'h0, 4'h0, 1'b0);
    rst       = 1'b0;
    bus.up_dn = 1'b0;
    bus.en    = 1'b1;
    step();
    check_out("dn_wrap", 4'h8, 4'hF, 1'b1);
    step();
    check_out("dn_e", 4'h9, 4'hE, 1'b0);
    bus.up_dn = 1'b1;
    step();
    check_out("up_again", 4'h8, 4'hF, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Registered Gray-code counter with parallel load. It keeps a binary count internally and drives both the binary value and its Gray-coded form from flops. It is the encode-side counterpart of the existing Gray-to-binary decoder. Its main use is as the write/read pointer source for asynchronous FIFOs, where the Gray output is synchronised into another clock domain and decoded there.

## Interface
- DATA_WIDTH, 32, counter width in bits; minimum 2.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; advances the counter one step per cycle while high.
- load  input  1  parallel load strobe.
- load_gray  input  DATA_WIDTH  Gray-coded load value, sampled when load=1.
- up_dn  input  1  count direction: 1=up, 0=down. Present only with GRAY_COUNTER_UPDN_EN.
- gray_out  output  DATA_WIDTH  registered Gray code of the current count.
- binary_out  output  DATA_WIDTH  registered binary current count.
- wrap  output  1  one-cycle pulse on count wrap-around.

## Operation
- State: binary register bin_q, Gray register gray_q, wrap register wrap_q. No FSM beyond the count register.
- Per-edge priority: rst > load > en > hold.
  - rst: bin_q=0, gray_q=0, wrap_q=0.
  - load: bin_q = gray-decode(load_gray), where bit i = XOR of load_gray[DATA_WIDTH-1:i]. gray_q = load_gray. wrap_q=0.
  - en: bin_next = bin_q + 1 modulo 2^DATA_WIDTH (down mode: bin_q − 1). gray_q = bin_next ^ (bin_next >> 1).
  - hold: all registers keep their value. wrap_q=0.
- gray_q is computed from bin_next in the same cycle. It is never derived from bin_q after the fact, so gray_out and binary_out always describe the same count.
- Single-bit change guarantee:
  - Every en step changes exactly one bit of gray_out, including the wrap step.
  - A load may change any number of bits. Loads are not CDC-safe and must happen only while the receiving domain ignores the pointer.
- wrap_q=1 only for an en step that crosses the boundary:
  - up: all-ones -> 0.
  - down: 0 -> all-ones.
  - A load never raises wrap.
- Width rules: all arithmetic is DATA_WIDTH wide; carry and borrow are discarded. No saturation.
- gray_out comes straight from flops with no output logic, so it is glitch-free for synchronisers.

## Timing
- Reset values: gray_out=0, binary_out=0, wrap=0. These are valid after the first rising edge with rst=1.
- Latency: 1 cycle. en, load, load_gray and up_dn are sampled on an edge; the outputs reflect them immediately after that edge.
- wrap is high for exactly the one cycle following the wrapping edge. It is not sticky.
- load=1 and en=1 together: the load wins, there is no increment that cycle, and wrap=0.
- rst asserted mid-count, or together with load or en: the counter clears on that edge and all other inputs are ignored.
- Back-to-back en (continuous counting) is fully supported at one step per cycle.
- up_dn may change on any cycle; it takes effect on the next en edge.

## Configuration
- GRAY_COUNTER_UPDN_EN defined:
  - the up_dn port exists;
  - up_dn=0 decrements;
  - wrap also fires on 0 -> all-ones.
- GRAY_COUNTER_UPDN_EN undefined:
  - the up_dn port is absent;
  - the counter is up-only;
  - no decrement logic is synthesised.

## Test plan
- Reset: DATA_WIDTH=4, rst=1 with en=1 and load=1 for one edge -> gray_out=0, binary_out=0, wrap=0.
- Full up cycle: DATA_WIDTH=4, en held high for 16 edges.
  - gray_out must step 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Hamming distance between successive values must be 1 at every step.
  - wrap=1 only in the cycle after binary F->0.
- Load: load=1, load_gray=4'hC, en=1 -> next cycle binary_out=8, gray_out=C, wrap=0. One further en edge -> binary_out=9, gray_out=D.
- Hold: counter at binary 5 (gray 7), en=0 and load=0 for 10 cycles -> outputs unchanged, wrap=0.
- Down wrap (GRAY_COUNTER_UPDN_EN defined): from reset, up_dn=0, en=1 for one edge -> binary_out=F, gray_out=8, wrap=1 for one cycle. Next down step -> binary_out=E, gray_out=9.
- Mid-count reset: counter at binary B with en=1, assert rst for one edge -> all outputs 0. Deassert rst -> the count resumes 1, 2, … on the following en edges.
